button_conditioner_multi: RTL and testbench

Parametrised, multi-channel successor to the single-button sync/debounce/pulse chain used by the seven-segment games top. Each of N_BTN raw pushbutton inputs is synchronised, debounced and converted into a clean level plus one-cycle press/release pulses, a long-press pulse and, optionally, auto-repeat pulses. It sits directly after the ui_in pins in tt_um_seven_segment_games and feeds the game FSMs (dice, counter, higher/lower, binary quiz).

---
 rtl/button_conditioner_multi.sv | 203 ++++++++++++++++++++
 tb/tb_button_conditioner_multi.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner_multi.sv
// -----------------------------------------------------------------------------
// button_conditioner_multi
//
// Purpose: N_BTN independent pushbutton conditioners. Each channel synchronises
// its raw pin, debounces it into a clean registered level, and produces
// one-cycle press/release pulses, a single long-press pulse per hold and,
// when built with BUTTON_AUTO_REPEAT_EN defined, periodic auto-repeat pulses
// while the button stays held after the long press.
//
// Optional feature macro: BUTTON_AUTO_REPEAT_EN
//   undefined (default): no repeat counter, repeat_pulse tied to 0.
//   defined            : repeat_pulse fires every REPEAT_CYCLES enabled
//                        cycles while in the long-held state.
//
// Ports:
//   clk            in   system clock
//   rst_n          in   asynchronous active-low reset
//   ena            in   1 = run; 0 = freeze counters/level/FSM, pulses forced 0
//                       (input synchronisers keep shifting)
//   btn_raw        in   [N_BTN] raw asynchronous button pins
//   level          out  [N_BTN] debounced pressed level (registered)
//   press          out  [N_BTN] one-cycle pulse on accepted press
//   release_o      out  [N_BTN] one-cycle pulse on accepted release
//   long_press     out  [N_BTN] one-cycle pulse once per hold
//   repeat_pulse   out  [N_BTN] one-cycle auto-repeat pulses
//   hold_state_dbg out  [2*N_BTN] per-channel hold FSM state, channel g at
//                       bits [2g+1:2g] (0 released, 1 held, 2 long)
//
// Handshake: none. All outputs are plain registered levels/pulses; a pulse is
// high for exactly the one cycle following the clock edge that produced it.
// -----------------------------------------------------------------------------
module button_conditioner_multi #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LONG_CYCLES     = 50000,
  parameter int REPEAT_CYCLES   = 10000,
  parameter int ACTIVE_LOW      = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   level,
  output logic [N_BTN-1:0]   press,
  output logic [N_BTN-1:0]   release_o,
  output logic [N_BTN-1:0]   long_press,
  output logic [N_BTN-1:0]   repeat_pulse,
  output logic [2*N_BTN-1:0] hold_state_dbg
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;
`endif

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_HELD     = 2'd1,
    ST_LONG     = 2'd2
  } hold_state_e;

  // Normalise polarity before synchronising so every later stage sees 1 = pressed.
  logic [N_BTN-1:0] raw_pressed;
  assign raw_pressed = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   rise, fall;
    hold_state_e            state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   press_q, release_q, long_q, long_d;
`ifdef BUTTON_AUTO_REPEAT_EN
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic                   rep_q, rep_d;
`endif

    // Synchroniser: keeps shifting even while disabled so it is fresh on resume.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw_pressed[g]};
    end
    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive enabled
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      if (ena) begin
        if (s == level_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d  = ~level_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // Hold FSM next state. A falling level overrides everything, so a release
    // on the long-press (or repeat) edge suppresses that pulse.
    always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      long_d     = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_d  = rep_cnt_q;
      rep_d      = 1'b0;
`endif
      if (ena) begin
        if (fall) begin
          state_d = ST_RELEASED;
        end else begin
          case (state_q)
            ST_RELEASED: begin
              if (rise) begin
                state_d    = ST_HELD;
                hold_cnt_d = '0;
              end
            end
            ST_HELD: begin
              if (hold_cnt_q == HOLD_W'(LONG_CYCLES - 1)) begin
                long_d  = 1'b1;
                state_d = ST_LONG;
`ifdef BUTTON_AUTO_REPEAT_EN
                rep_cnt_d = '0;
`endif
              end else begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
              end
            end
            ST_LONG: begin
`ifdef BUTTON_AUTO_REPEAT_EN
              if (rep_cnt_q == REP_W'(REPEAT_CYCLES - 1)) begin
                rep_d     = 1'b1;
                rep_cnt_d = '0;
              end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
              end
`endif
            end
            default: state_d = ST_RELEASED;
          endcase
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q   <= '0;
        level_q    <= 1'b0;
        state_q    <= ST_RELEASED;
        hold_cnt_q <= '0;
        press_q    <= 1'b0;
        release_q  <= 1'b0;
        long_q     <= 1'b0;
      end else begin
        db_cnt_q   <= db_cnt_d;
        level_q    <= level_d;
        state_q    <= state_d;
        hold_cnt_q <= hold_cnt_d;
        press_q    <= rise;
        release_q  <= fall;
        long_q     <= long_d;
      end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rep_cnt_q <= '0;
        rep_q     <= 1'b0;
      end else begin
        rep_cnt_q <= rep_cnt_d;
        rep_q     <= rep_d;
      end
    end
    assign repeat_pulse[g] = rep_q;
`endif

    assign level[g]                 = level_q;
    assign press[g]                 = press_q;
    assign release_o[g]             = release_q;
    assign long_press[g]            = long_q;
    assign hold_state_dbg[2*g +: 2] = state_q;
  end

`ifndef BUTTON_AUTO_REPEAT_EN
  // No repeat logic in this build; the period still appears in the tie-off
  // expression so the parameter stays referenced.
  assign repeat_pulse = {N_BTN{1'b0}} & {N_BTN{REPEAT_CYCLES > 0}};
`endif

endmodule

// File: tb/tb_button_conditioner_multi.sv
// -----------------------------------------------------------------------------
// Testbench for button_conditioner_multi (N_BTN=4, SYNC=2, DEBOUNCE=4,
// LONG=20, REPEAT=5, ACTIVE_LOW=0). A reference model driven by the bench's
// own stimulus pushes every expected output event into exp_q; a monitor on
// the falling edge pops and compares whenever the DUT shows a pulse or an
// event is due. The model works on histories: a level flips when the last
// DEBOUNCE enabled samples all disagree with it, and hold events are placed
// by counting enabled edges since the accepted press.
// -----------------------------------------------------------------------------
module tb_button_conditioner_multi;
  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif
  localparam int W = 36;  // {cycle[15:0], level, press, release, long, repeat}

  // ---------------- clock / reset / DUT ----------------
  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena   = 1'b1;
  logic [N-1:0]   btn_raw = '0;
  logic [N-1:0]   level, press, release_o, long_press, repeat_pulse;
  logic [2*N-1:0] hold_state_dbg;

  always #5 clk = ~clk;

  button_conditioner_multi #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .btn_raw(btn_raw),
    .level(level), .press(press), .release_o(release_o),
    .long_press(long_press), .repeat_pulse(repeat_pulse),
    .hold_state_dbg(hold_state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  int           cyc = 0;        // clock edges since reset released
  int           en_idx = 0;     // enabled edges since reset released
  logic [N-1:0] raw_hist[$];    // raw_hist[k-1] = pins sampled at edge k
  logic [N-1:0] en_s_hist[$];   // synchronised values seen on enabled edges
  logic [N-1:0] mlevel = '0;
  int           rise_idx[N];

  always @(posedge clk) begin
    logic [N-1:0] s, lv_new, p, r, l, rp;
    logic         all_diff;
    int           k;
    if (!rst_n) begin
      cyc    = 0;
      en_idx = 0;
      raw_hist.delete();
      en_s_hist.delete();
      mlevel = '0;
    end else begin
      cyc++;
      raw_hist.push_back(btn_raw);
      // A pin value reaches the debouncer SYNC edges after it is sampled.
      s = (cyc - SYNC >= 1) ? raw_hist[cyc - SYNC - 1] : '0;
      p = '0; r = '0; l = '0; rp = '0;
      lv_new = mlevel;
      if (ena) begin
        en_idx++;
        en_s_hist.push_back(s);
        if (en_s_hist.size() > DEB) void'(en_s_hist.pop_front());
        for (int c = 0; c < N; c++) begin
          if (en_s_hist.size() >= DEB) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
              if (en_s_hist[j][c] == mlevel[c]) all_diff = 1'b0;
            if (all_diff) lv_new[c] = ~mlevel[c];
          end
        end
        p = lv_new & ~mlevel;
        r = ~lv_new & mlevel;
        for (int c = 0; c < N; c++) begin
          if (p[c]) begin
            rise_idx[c] = en_idx;
          end else if (lv_new[c]) begin
            k = en_idx - rise_idx[c];
            if (k == LONG) l[c] = 1'b1;
            else if (REP_ON && k > LONG && ((k - LONG) % REP) == 0) rp[c] = 1'b1;
          end
        end
        mlevel = lv_new;
      end
      if ((p | r | l | rp) != '0)
        exp_q.push_back({cyc[15:0], mlevel, p, r, l, rp});
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act, expw;
    logic         any;
    any = |{press, release_o, long_press, repeat_pulse};
    if (rst_n) begin
      total++;
      if (level !== mlevel) begin
        bad++;
        $display("FAIL level cyc=%0d act=%h exp=%h", cyc, level, mlevel);
      end
    end
    if (any || exp_q.size() > 0) begin
      act = {cyc[15:0], level, press, release_o, long_press, repeat_pulse};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL spurious_pulse act=%h exp=none", act);
      end else begin
        expw = exp_q.pop_front();
        if (act !== expw) begin
          bad++;
          $display("FAIL pulse_event act=%h exp=%h", act, expw);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(level), 32'h0);
    check({tag, "_press"}, 32'(press), 32'h0);
    check({tag, "_release"}, 32'(release_o), 32'h0);
    check({tag, "_long"}, 32'(long_press), 32'h0);
    check({tag, "_repeat"}, 32'(repeat_pulse), 32'h0);
    check({tag, "_state"}, 32'(hold_state_dbg), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with all buttons pressed: everything stays quiet.
    btn_raw = 4'hF;
    wait_cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    wait_cyc(30);
    btn_raw = 4'h0;
    wait_cyc(15);

    // Bounce on channel 0, then a short glitch alone.
    btn_raw[0] = 1'b1; wait_cyc(3);
    btn_raw[0] = 1'b0; wait_cyc(1);
    btn_raw[0] = 1'b1; wait_cyc(30);
    btn_raw[0] = 1'b0; wait_cyc(15);
    btn_raw[0] = 1'b1; wait_cyc(2);
    btn_raw[0] = 1'b0; wait_cyc(15);

    // Long hold on channel 1 (repeats when built with the feature).
    btn_raw[1] = 1'b1; wait_cyc(45);
    btn_raw[1] = 1'b0; wait_cyc(15);

    // Disable for 10 cycles mid-hold on channel 2.
    btn_raw[2] = 1'b1; wait_cyc(16);
    ena = 1'b0;        wait_cyc(10);
    ena = 1'b1;        wait_cyc(30);
    btn_raw[2] = 1'b0; wait_cyc(15);

    // Channels 0 and 3 together; channel 3 released on its long-press edge.
    btn_raw[0] = 1'b1; btn_raw[3] = 1'b1; wait_cyc(20);
    btn_raw[3] = 1'b0; wait_cyc(20);
    btn_raw[0] = 1'b0; wait_cyc(15);

    // Reset in the middle of a hold: no release afterwards.
    btn_raw[2] = 1'b1; wait_cyc(20);
    #1 rst_n = 1'b0;
    wait_cyc(3);
    check_all_zero("midreset");
    btn_raw = 4'h0;
    rst_n = 1'b1;
    wait_cyc(15);

    // Random pins with occasional disabled cycles.
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 39) == 0) btn_raw[c] = ~btn_raw[c];
      ena = ($urandom_range(0, 19) != 0);
      wait_cyc(1);
    end
    ena = 1'b1;
    btn_raw = 4'h0;
    wait_cyc(40);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
